// File: rtl/updown_event_counter.sv
// Push-button up/down event counter: synchronised inputs, rising-edge events, wrap/saturate.
// Optional input debounce filter enabled by `define UPDOWN_EVENT_COUNTER_DEBOUNCE_EN.
module updown_event_counter #(
    parameter int WIDTH           = 4,
    parameter int MAX_VAL         = 9,
    parameter int WRAP            = 1,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             carry,
    output logic             borrow
);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    generate
        if (MAX_VAL < 1 || MAX_VAL > (2 ** WIDTH) - 1) begin : g_bad_max_val
            $error("updown_event_counter: MAX_VAL out of range 1..2**WIDTH-1");
        end
    endgenerate

    logic [1:0] inc_sync;
    logic [1:0] dec_sync;
    logic [1:0] sync_lvl;
    logic [1:0] filt;
    logic [1:0] prev;
    logic [1:0] evt;
    logic       inc_evt;
    logic       dec_evt;

    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] load_clamped;
    logic             carry_next;
    logic             borrow_next;

    // Two-flop synchronisers for the raw button levels.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inc_sync <= '0;
            dec_sync <= '0;
        end else begin
            inc_sync <= {inc_sync[0], inc};
            dec_sync <= {dec_sync[0], dec};
        end
    end

    assign sync_lvl = {dec_sync[1], inc_sync[1]};

`ifdef UPDOWN_EVENT_COUNTER_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] db_cnt [2];

    // Filtered level flips only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            filt <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_lvl[i] != filt[i]) begin
                    if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                        filt[i]   <= sync_lvl[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + CW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end
`else
    assign filt = sync_lvl;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev <= '0;
        end else begin
            prev <= filt;
        end
    end

    assign evt     = filt & ~prev;
    assign inc_evt = evt[0];
    assign dec_evt = evt[1];

    assign load_clamped = (load_val > MAX_W) ? MAX_W : load_val;

    // clr beats load beats events; simultaneous inc/dec events cancel out.
    always_comb begin
        count_next  = count;
        carry_next  = 1'b0;
        borrow_next = 1'b0;
        if (clr) begin
            count_next = '0;
        end else if (load) begin
            count_next = load_clamped;
        end else if (en && inc_evt && !dec_evt) begin
            if (count == MAX_W) begin
                carry_next = 1'b1;
                count_next = (WRAP != 0) ? '0 : MAX_W;
            end else begin
                count_next = count + WIDTH'(1);
            end
        end else if (en && dec_evt && !inc_evt) begin
            if (count == '0) begin
                borrow_next = 1'b1;
                count_next  = (WRAP != 0) ? MAX_W : '0;
            end else begin
                count_next = count - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count  <= '0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            count  <= count_next;
            carry  <= carry_next;
            borrow <= borrow_next;
        end
    end

    assign at_max = (count == MAX_W);
    assign at_min = (count == '0);

endmodule
